// File: rtl/md_unit.sv
// ============================================================================
// md_unit: multi-cycle multiply/divide unit owning HI/LO (option: MDU_DIV0_KEEP_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int C_MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(C_MAX_N + 1);
  localparam logic [CNT_W-1:0] C_MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic w_accept;
  logic w_commit;
  logic w_mt_ok;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && !req) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == C_ONE) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode; start has priority over mthi/mtlo in the same cycle
  always_comb begin
    busy     = (r_state == S_RUN);
    w_accept = start && !req && (r_state == S_IDLE);
    w_commit = (r_state == S_RUN) && (r_cnt == C_ONE);
    w_mt_ok  = !start && !req && (r_state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= 2'b00;
      r_a   <= 32'h0;
      r_b   <= 32'h0;
    end else if (w_accept) begin
      r_cnt <= md_op[1] ? C_DIV_N : C_MULT_N;
      r_op  <= md_op;
      r_a   <= in1;
      r_b   <= in2;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - C_ONE;
    end
  end

  logic               w_div0;
  logic               w_ovf;
  logic [31:0]        w_dvsr;
  logic [63:0]        w_a_sx;
  logic [63:0]        w_b_sx;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic signed [31:0] w_q_s;
  logic signed [31:0] w_r_s;
  logic [31:0]        w_q_u;
  logic [31:0]        w_r_u;
  logic [63:0]        w_res;
  logic               w_res_we;

  // Divisor is forced to 1 for /0 and INT_MIN/-1 so the dividers never see an
  // undefined case; those results are then patched or already correct.
  assign w_div0   = (r_b == 32'h0);
  assign w_ovf    = (r_op == 2'b10) && (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
  assign w_dvsr   = (w_div0 || w_ovf) ? 32'd1 : r_b;
  assign w_a_sx   = {{32{r_a[31]}}, r_a};
  assign w_b_sx   = {{32{r_b[31]}}, r_b};
  assign w_prod_s = $signed(w_a_sx) * $signed(w_b_sx);
  assign w_prod_u = {32'h0, r_a} * {32'h0, r_b};
  assign w_q_s    = $signed(r_a) / $signed(w_dvsr);
  assign w_r_s    = $signed(r_a) % $signed(w_dvsr);
  assign w_q_u    = r_a / w_dvsr;
  assign w_r_u    = r_a % w_dvsr;

  always_comb begin
    w_res    = 64'h0;
    w_res_we = 1'b1;
    case (r_op)
      2'b00:   w_res = w_prod_s;
      2'b01:   w_res = w_prod_u;
      2'b10:   w_res = {w_r_s, w_q_s};
      default: w_res = {w_r_u, w_q_u};
    endcase
    if (r_op[1] && w_div0) begin
`ifdef MDU_DIV0_KEEP_EN
      w_res_we = 1'b0;
`else
      w_res = {r_a, 32'hFFFF_FFFF};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= 32'h0;
      r_lo <= 32'h0;
    end else if (w_commit) begin
      if (w_res_we) begin
        r_hi <= w_res[63:32];
        r_lo <= w_res[31:0];
      end
    end else begin
      if (w_mt_ok && hi_we) r_hi <= in1;
      if (w_mt_ok && lo_we) r_lo <= in1;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// tb_md_unit: scoreboard bench for md_unit (honours MDU_DIV0_KEEP_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  md_op = 2'b00;
  logic [31:0] in1 = 32'h0;
  logic [31:0] in2 = 32'h0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sbq[$];
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req(req), .start(start), .md_op(md_op),
    .in1(in1), .in2(in2), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .hi(hi), .lo(lo)
  );

  // Reference: signed divide via magnitudes, then re-apply signs
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    longint      sa, sbv;
    model = 64'h0;
    case (op)
      2'd0: begin
        sa    = longint'($signed(a));
        sbv   = longint'($signed(b));
        model = 64'(sa * sbv);
      end
      2'd1: model = {32'h0, a} * {32'h0, b};
      default: begin
        if (b == 32'h0) begin
`ifdef MDU_DIV0_KEEP_EN
          model = {m_hi, m_lo};
`else
          model = {a, 32'hFFFF_FFFF};
`endif
        end else if (op == 2'd3) begin
          model = {a % b, a / b};
        end else begin
          ua = a[31] ? -a : a;
          ub = b[31] ? -b : b;
          q  = ua / ub;
          r  = ua % ub;
          if (a[31] ^ b[31]) q = -q;
          if (a[31]) r = -r;
          model = {r, q};
        end
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    md_op = op; in1 = a; in2 = b; start = 1'b1;
    e = model(op, a, b);
    sbq.push_back(e);
    {m_hi, m_lo} = e;
    tick();
    start = 1'b0;
    in1 = $urandom;
    in2 = $urandom;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    repeat (3) tick();
    checks++;
    if ({busy, hi, lo} !== 65'h0) begin errors++; $display("FAIL idle_hold: got %b/%h/%h expected 0/0/0", busy, hi, lo); end
  endtask

  task automatic test_mult();
    int cyc; logic [63:0] e;
    for (int k = 0; k < 2; k++) begin
      issue(2'(k), 32'hFFFF_FFFE, 32'd3);
      wait_done(0, cyc);
      checks++; if (cyc != 5) begin errors++; $display("FAIL mult_busy op%0d: got %0d expected 5", k, cyc); end
      e = sbq.pop_front();
      checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL mult_res op%0d: got %h expected %h", k, {hi, lo}, e); end
    end
  endtask

  task automatic test_div();
    int cyc; logic [63:0] e;
    logic [1:0]  ops[3] = '{2'd2, 2'd3, 2'd2};
    logic [31:0] as[3]  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] bs[3]  = '{32'd2, 32'd2, 32'hFFFF_FFFF};
    for (int k = 0; k < 3; k++) begin
      issue(ops[k], as[k], bs[k]);
      wait_done(0, cyc);
      checks++; if (cyc != 10) begin errors++; $display("FAIL div_busy %0d: got %0d expected 10", k, cyc); end
      e = sbq.pop_front();
      checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL div_res %0d: got %h expected %h", k, {hi, lo}, e); end
    end
  endtask

  task automatic test_random();
    int cyc; logic [63:0] e; logic [1:0] op; logic [31:0] a, b;
    for (int k = 0; k < 6; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (k == 3) ? 32'h0 : ((k[0]) ? 32'($urandom_range(1, 300)) : $urandom);
      if (k == 4) a = 32'hFFFF_FF00;
      issue(op, a, b);
      wait_done(0, cyc);
      e = sbq.pop_front();
      checks++;
      if ({hi, lo} !== e || cyc != (op[1] ? 10 : 5)) begin
        errors++;
        $display("FAIL rand %0d op%0d a=%h b=%h: got %h/%0d expected %h/%0d", k, op, a, b, {hi, lo}, cyc, e, op[1] ? 10 : 5);
      end
    end
  endtask

  task automatic test_req();
    int cyc; logic [63:0] e;
    req = 1'b1; start = 1'b1; md_op = 2'd0; in1 = 32'd5; in2 = 32'd6;
    tick();
    start = 1'b0; req = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req_start_busy: got %b expected 0", busy); end
    tick();
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL req_start_hilo: got %h expected %h", {hi, lo}, {m_hi, m_lo}); end
    issue(2'd0, 32'h1234_5678, 32'hFFFF_0001);
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_done(2, cyc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL req_run_busy: got %0d expected 5", cyc); end
    e = sbq.pop_front();
    checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL req_run_res: got %h expected %h", {hi, lo}, e); end
  endtask

  task automatic test_writes();
    int cyc; logic [63:0] e;
    issue(2'd1, 32'h10, 32'h20);
    lo_we = 1'b1; in1 = 32'h1234;
    tick();
    lo_we = 1'b0;
    wait_done(1, cyc);
    e = sbq.pop_front();
    checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL lo_we_busy: got %h expected %h", {hi, lo}, e); end
    lo_we = 1'b1; in1 = 32'h1234;
    tick();
    lo_we = 1'b0;
    m_lo = 32'h1234;
    checks++; if (lo !== 32'h1234) begin errors++; $display("FAIL lo_we_idle: got %h expected 00001234", lo); end
    hi_we = 1'b1; in1 = 32'hABCD_0000;
    tick();
    hi_we = 1'b0;
    m_hi = 32'hABCD_0000;
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL hi_we_idle: got %h expected %h", {hi, lo}, {m_hi, m_lo}); end
    hi_we = 1'b1;
    issue(2'd0, 32'd5, 32'd7);
    hi_we = 1'b0;
    wait_done(0, cyc);
    e = sbq.pop_front();
    checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL start_hi_we: got %h expected %h", {hi, lo}, e); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic [63:0] e;
    issue(2'd1, 32'd3, 32'd4);
    md_op = 2'd2; in1 = 32'd100; in2 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1, cyc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL busy_start_len: got %0d expected 5", cyc); end
    e = sbq.pop_front();
    checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL busy_start_res: got %h expected %h", {hi, lo}, e); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_ghost: got %b expected 0", busy); end
  endtask

  task automatic test_div0();
    int cyc; logic [63:0] e;
    for (int k = 2; k < 4; k++) begin
      issue(2'(k), (k == 2) ? 32'h55 : 32'h8000_0077, 32'h0);
      wait_done(0, cyc);
      checks++; if (cyc != 10) begin errors++; $display("FAIL div0_busy op%0d: got %0d expected 10", k, cyc); end
      e = sbq.pop_front();
      checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL div0_res op%0d: got %h expected %h", k, {hi, lo}, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] e;
    issue(2'd2, 32'd100, 32'd3);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e = sbq.pop_back();
    m_hi = 32'h0; m_lo = 32'h0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst_mid_hilo: got %h expected 0 (aborted %h)", {hi, lo}, e); end
    repeat (12) tick();
    checks++; if ({busy, hi, lo} !== 65'h0) begin errors++; $display("FAIL rst_mid_late: got %b/%h/%h expected 0/0/0", busy, hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_random();
    test_req();
    test_writes();
    test_back_to_back();
    test_div0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
